// File: rtl/pipeline_pkg.sv
// Shared types and widths for the display-tap controller.
// The greyscale taps are widened to RGB444 by copying the grey value into all three channels.
package pipeline_pkg;

  typedef enum logic [1:0] {
    VIEW_RGB   = 2'd0,
    VIEW_GREY  = 2'd1,
    VIEW_GAUSS = 2'd2,
    VIEW_EDGE  = 2'd3
  } view_e;

  typedef enum logic {
    STREAM  = 1'b0,
    PENDING = 1'b1
  } view_state_e;

  localparam int PIX_W  = 12;
  localparam int GREY_W = 4;

  function automatic logic [PIX_W-1:0] grey_expand(input logic [GREY_W-1:0] g);
    return {g, g, g};
  endfunction

endpackage

// File: rtl/pipeline_view_ctrl_key_debounce.sv
// Pushbutton front end: 2-flop synchronizer, debounce down-counter, press pulse.
// press is high in the cycle before the debounced level falls, so the pulse is seen at that same edge.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;
  logic          flip;

  // Terminal count reached while the synchronized input still disagrees with the debounced level.
  assign flip  = (sync2 != level) && (cnt == '0);
  assign press = flip && level;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= RELOAD;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      if (sync2 == level || cnt == '0) cnt <= RELOAD;
      else                            cnt <= cnt - CW'(1);
      if (flip) level <= sync2;
    end
  end

endmodule

// File: rtl/pipeline_view_ctrl.sv
// Display-tap selector: switches the VGA source between pipeline stages on frame boundaries only.
//   state   | meaning
//   STREAM  | forwarding view_sel, accepting press / auto requests
//   PENDING | next_sel latched, waiting for that tap's last pixel
module pipeline_view_ctrl
  import pipeline_pkg::*;
#(
  parameter int IMG_W        = 640,
  parameter int IMG_H        = 480,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int AUTO_FRAMES  = 120
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_next_n,
  input  logic              auto_en,
  input  logic [PIX_W-1:0]  rgb_in,
  input  logic              rgb_ready,
  input  logic [GREY_W-1:0] grey_in,
  input  logic              grey_ready,
  input  logic [GREY_W-1:0] gauss_in,
  input  logic              gauss_ready,
  input  logic [GREY_W-1:0] edge_in,
  input  logic              edge_ready,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              out_ready,
  output logic [1:0]        view_sel,
  output logic              switch_pending,
  output logic              frame_done
);

  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam int CNT_W     = $clog2(FRAME_PIX);
  localparam int FC_W      = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(AUTO_FRAMES - 1);

  logic [3:0]       tap_ready;
  logic [3:0]       tap_last;
  logic [PIX_W-1:0] tap_pix [4];

  assign tap_ready = {edge_ready, gauss_ready, grey_ready, rgb_ready};
  assign tap_pix[0] = rgb_in;
  assign tap_pix[1] = grey_expand(grey_in);
  assign tap_pix[2] = grey_expand(gauss_in);
  assign tap_pix[3] = grey_expand(edge_in);

  // Each tap has its own latency, so each keeps its own frame position.
  for (genvar t = 0; t < 4; t++) begin : g_tap
    logic [CNT_W-1:0] pix_cnt;
    assign tap_last[t] = tap_ready[t] && (pix_cnt == CNT_W'(FRAME_PIX - 1));
    always_ff @(posedge clk) begin
      if (rst)               pix_cnt <= '0;
      else if (tap_ready[t]) pix_cnt <= tap_last[t] ? '0 : pix_cnt + CNT_W'(1);
    end
  end

  logic        press;
  view_state_e state_q, state_d;
  view_e       view_sel_q, next_sel_q;
  logic [FC_W-1:0] fcnt;
  logic        sel_last, next_last, auto_req, req, switch_now;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_next_n),
    .press (press)
  );

  assign sel_last   = tap_last[view_sel_q];
  assign next_last  = tap_last[next_sel_q];
  // Frame timer counts down; terminal count on a selected-tap last raises the auto request.
  assign auto_req   = auto_en && sel_last && (fcnt == '0);
  assign req        = press || auto_req;
  assign switch_now = (state_q == PENDING) && next_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      STREAM:  if (req)       state_d = PENDING;
      PENDING: if (next_last) state_d = STREAM;
      default:                state_d = STREAM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= STREAM;
      view_sel_q <= VIEW_RGB;
      next_sel_q <= VIEW_RGB;
      fcnt       <= FC_RELOAD;
      pixel_out  <= '0;
      out_ready  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == STREAM && req) next_sel_q <= view_e'(view_sel_q + 2'd1);
      if (switch_now)               view_sel_q <= next_sel_q;
      if (!auto_en || switch_now)   fcnt <= FC_RELOAD;
      else if (sel_last)            fcnt <= (fcnt == '0) ? FC_RELOAD : fcnt - FC_W'(1);
      pixel_out  <= tap_pix[view_sel_q];
      out_ready  <= tap_ready[view_sel_q];
      frame_done <= sel_last;
    end
  end

  assign view_sel       = view_sel_q;
  assign switch_pending = (state_q == PENDING);

endmodule

// File: doc/pipeline_view_ctrl.md
# pipeline_view_ctrl

Display-tap controller for the camera-to-VGA image pipeline. It selects which stage drives the VGA path: raw RGB from the image buffer, greyscale, Gaussian-denoised, or Sobel edge. A debounced pushbutton or an auto-cycle timer requests a switch, and the block applies it only on a frame boundary of the incoming tap, so the display never shows a torn frame. It sits between the filter chain outputs and `grey_to_rgb`/`vga_driver`, and replaces the fixed edge-to-VGA wiring.

## Interface
- `IMG_W`, 640, pixels per line
- `IMG_H`, 480, lines per frame
- `DEBOUNCE_CYC`, 250000, stable-level cycles required on the key (10 ms at 25 MHz)
- `AUTO_FRAMES`, 120, selected-tap frames between automatic advances

- `clk`  in  1  video clock (`clk_video`)
- `rst`  in  1  synchronous, active-high reset
- `key_next_n`  in  1  raw active-low pushbutton, asynchronous to `clk`
- `auto_en`  in  1  enables auto-cycle
- `rgb_in`  in  12  RGB444 tap; `rgb_ready`  in  1  its valid strobe
- `grey_in`  in  4  grey tap; `grey_ready`  in  1
- `gauss_in`  in  4  Gaussian tap; `gauss_ready`  in  1
- `edge_in`  in  4  edge tap; `edge_ready`  in  1
- `pixel_out`  out  12  selected pixel, RGB444
- `out_ready`  out  1  valid for `pixel_out`
- `view_sel`  out  2  current view: 0 rgb, 1 grey, 2 gauss, 3 edge
- `switch_pending`  out  1  a request is latched and waiting for a boundary
- `frame_done`  out  1  one-cycle pulse on the selected tap's last pixel

## Operation
- **Key input:** 2-flop synchronizer, then debounce.
  - The debounced level changes only after the synchronized input holds a new level for `DEBOUNCE_CYC` consecutive cycles.
  - A debounced high→low transition produces a one-cycle `press`.
- **Pixel counters:** one per tap, each width `$clog2(IMG_W*IMG_H)` (19 bits at default).
  - A counter increments on its own ready strobe.
  - It wraps from `IMG_W*IMG_H-1` to 0; a wrap is that tap's `last`.
  - Taps have different pipeline latencies, so the counters are independent.
  - All counters reset to 0, which aligns them with upstream resets on the shared `rst`.
- **Frame counter:** counts the selected tap's `last` events, 0..`AUTO_FRAMES-1`.
  - It clears on every switch and when `auto_en`=0.
  - With `auto_en`=1, a `last` event at count `AUTO_FRAMES-1` produces `auto_req`.
- **FSM states:** STREAM, PENDING.
  - STREAM → PENDING on `press | auto_req`; latch `next_sel = view_sel+1` (mod 4, 3 wraps to 0).
  - PENDING → STREAM on `last` of the `next_sel` tap. `view_sel <= next_sel` in the same edge, so the new tap's pixel 0 is its first output.
  - A `press` or `auto_req` arriving while in PENDING is ignored; requests do not accumulate.
  - If a `press` and `auto_req` arrive in the same cycle, they make a single request.
- **Output mux (registered):**
  - `pixel_out <= ` selected data; 4-bit taps expand to `{g,g,g}`.
  - `out_ready <= ` selected ready.
  - `frame_done <= ` selected tap's `last`.
- `switch_pending` is 1 exactly in PENDING.
- **Reset:** state STREAM, `view_sel`=0, `pixel_out`=0, `out_ready`=0, `frame_done`=0, `switch_pending`=0, all counters 0, debounced level high. A reset during PENDING discards the request.

## Timing
- Mux latency is 1 cycle: the input strobe at cycle N appears as `out_ready` at N+1.
- Press latency: a key going low at cycle K asserts `switch_pending` within K+2+`DEBOUNCE_CYC`+1 cycles.
- Switch: the `next_sel` tap's `last` at cycle S sets `view_sel` at S+1. Output at S+1 still carries the old tap's registered sample. Output from the first new-tap strobe after S is new-tap data.
- No output strobe is duplicated or dropped from the selected stream. An old-tap strobe in the switch cycle is forwarded; strobes after it are not.
- Back-to-back strobes every cycle must be supported.

## Structure
- `pipeline_pkg`:
  - `view_e` enum (`VIEW_RGB`, `VIEW_GREY`, `VIEW_GAUSS`, `VIEW_EDGE`)
  - `view_state_e` (`STREAM`, `PENDING`)
  - `PIX_W` = 12 and `GREY_W` = 4
- Sub-module `key_debounce`: synchronizer, debounce counter and press pulse; parameter `DEBOUNCE_CYC`.
- Per-tap counters: `generate` loop in the top module.

## Test plan
Bench parameters: `IMG_W`=8, `IMG_H`=4 (32 px/frame), `DEBOUNCE_CYC`=4, `AUTO_FRAMES`=2.
1. **Reset and passthrough:** after reset, `view_sel`=0 and outputs 0. Drive `rgb_in`=0xABC with `rgb_ready` → next cycle `pixel_out`=0xABC, `out_ready`=1.
2. **Pending-then-switch:** hold `key_next_n` low 6 cycles while the grey counter is at 10 → `switch_pending`=1. After the 22nd further `grey_ready`, `view_sel`=1. The next `grey_in`=4'h5 yields `pixel_out`=0x555.
3. **Debounce rejection:** key low pulses of 3 cycles separated by 2 high cycles → no `press`, `switch_pending` stays 0.
4. **Ignored repeat press:** a second press during PENDING → only one advance. Four advances from 0 give `view_sel` 1,2,3,0.
5. **Auto-cycle:** `auto_en`=1 → `view_sel` advances after every 2 selected-tap `frame_done` pulses plus the wait for the next tap's boundary. A simultaneous press and `auto_req` → single advance.
6. **Reset mid-operation:** assert `rst` in PENDING → `switch_pending`=0, `view_sel`=0, counters 0, and no switch after release.
